jtdsp16_cache: RTL and testbench

Instruction cache and loop sequencer for the DSP16 core, implementing the `do K {N}` and `redo K` constructs. It sits between the program ROM and `jtdsp16_ctrl`. On the first pass it captures the N instructions fetched from ROM. It then replays them K-1 more times from a local register file while holding the ROM address unit. `jtdsp16_ctrl` consumes `cache_dout` whenever `cache_en` is high.

---
 rtl/jtdsp16_pkg.sv | 15 +
 rtl/jtdsp16_cache_mem.sv | 34 +++
 rtl/jtdsp16_cache.sv | 147 ++++++++++++++
 tb/tb_jtdsp16_cache.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtdsp16_pkg.sv
// jtdsp16_pkg
// Shared constants for the DSP16 instruction cache / loop sequencer:
// FSM state encodings and the depth of the cache register file.
package jtdsp16_pkg;

  typedef enum logic [1:0] {
    CACHE_IDLE   = 2'd0,
    CACHE_FILL   = 2'd1,
    CACHE_REPEAT = 2'd2
  } cache_state_t;

  // Capacity of the loop body store: 2^NW-1 with the default NW=4.
  localparam int CACHE_DEPTH = 15;

endpackage

// File: rtl/jtdsp16_cache_mem.sv
// jtdsp16_cache_mem
// Flop-based register file holding the captured loop body.
// Ports:
//   clk, rst        clock, asynchronous active-low clear of every slot
//   we, waddr, din  single write port (we is already qualified by cen)
//   raddr, dout     combinational read port, 0 for out-of-range addresses
module jtdsp16_cache_mem
  import jtdsp16_pkg::*;
#(
  parameter int DW = 16,
  parameter int NW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [NW-1:0] waddr,
  input  logic [DW-1:0] din,
  input  logic [NW-1:0] raddr,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [CACHE_DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CACHE_DEPTH; i++) mem[i] <= '0;
    end else if (we && int'(waddr) < CACHE_DEPTH) begin
      mem[waddr] <= din;
    end
  end

  assign dout = (int'(raddr) < CACHE_DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/jtdsp16_cache.sv
// jtdsp16_cache
// Instruction cache and loop sequencer for "do K {N}" / "redo K".
// The first pass captures N ROM words; the remaining passes replay them
// from the local store while the program counter is held.
// Ports:
//   clk, rst, cen        clock, async active-low reset, clock enable
//   do_start, redo       decoded loop instructions (sampled with cen)
//   do_n, do_k           loop body length N and iteration count K
//   step                 controller consumed one instruction this cycle
//   rom_dout             instruction currently fetched from ROM
//   cache_en, cache_dout instruction source select and cached word
//   pc_hold              freeze the program counter
//   busy                 loop in progress (interrupts masked)
//   loop_done            pulse on the final step of the last iteration
//   nest_err             sticky: do/redo seen while busy
//
// state        | meaning
// CACHE_IDLE   | no loop, instructions come from ROM
// CACHE_FILL   | first pass, ROM words are captured into the store
// CACHE_REPEAT | replay from the store, PC held
module jtdsp16_cache
  import jtdsp16_pkg::*;
#(
  parameter int DW = 16,
  parameter int NW = 4,
  parameter int KW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          do_start,
  input  logic          redo,
  input  logic [NW-1:0] do_n,
  input  logic [KW-1:0] do_k,
  input  logic          step,
  input  logic [DW-1:0] rom_dout,
  output logic          cache_en,
  output logic [DW-1:0] cache_dout,
  output logic          pc_hold,
  output logic          busy,
  output logic          loop_done,
  output logic          nest_err
);

  cache_state_t  state;
  logic [NW-1:0] n_r;
  logic [KW-1:0] k_cnt;
  logic [NW-1:0] slot;
  logic [KW-1:0] k_init;
  logic          last_slot;
  logic          mem_we;
  logic [DW-1:0] mem_dout;

  // K=0 behaves like K=1 so a loop always runs at least once.
  assign k_init    = (do_k == '0) ? KW'(1) : do_k;
  assign last_slot = (slot == n_r - NW'(1));
  assign mem_we    = cen && step && (state == CACHE_FILL);

  jtdsp16_cache_mem #(.DW(DW), .NW(NW)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (slot),
    .din   (rom_dout),
    .raddr (slot),
    .dout  (mem_dout)
  );

  assign cache_dout = cache_en ? mem_dout : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= CACHE_IDLE;
      n_r       <= '0;
      k_cnt     <= '0;
      slot      <= '0;
      cache_en  <= 1'b0;
      pc_hold   <= 1'b0;
      busy      <= 1'b0;
      loop_done <= 1'b0;
      nest_err  <= 1'b0;
    end else if (cen) begin
      loop_done <= 1'b0;
      case (state)
        CACHE_IDLE: begin
          // do_start has priority even when its N=0 makes it a no-op
          if (do_start) begin
            if (do_n != '0) begin
              n_r   <= do_n;
              k_cnt <= k_init;
              slot  <= '0;
              state <= CACHE_FILL;
              busy  <= 1'b1;
            end
          end else if (redo && n_r != '0) begin
            k_cnt    <= k_init;
            slot     <= '0;
            state    <= CACHE_REPEAT;
            busy     <= 1'b1;
            cache_en <= 1'b1;
            pc_hold  <= 1'b1;
          end
        end
        CACHE_FILL: begin
          if (do_start || redo) nest_err <= 1'b1;
          if (step) begin
            if (last_slot) begin
              slot <= '0;
              if (k_cnt <= KW'(1)) begin
                state     <= CACHE_IDLE;
                busy      <= 1'b0;
                loop_done <= 1'b1;
              end else begin
                k_cnt    <= k_cnt - KW'(1);
                state    <= CACHE_REPEAT;
                cache_en <= 1'b1;
                pc_hold  <= 1'b1;
              end
            end else begin
              slot <= slot + NW'(1);
            end
          end
        end
        CACHE_REPEAT: begin
          if (do_start || redo) nest_err <= 1'b1;
          if (step) begin
            if (last_slot) begin
              slot <= '0;
              if (k_cnt != '0) k_cnt <= k_cnt - KW'(1);
              if (k_cnt <= KW'(1)) begin
                state     <= CACHE_IDLE;
                cache_en  <= 1'b0;
                pc_hold   <= 1'b0;
                busy      <= 1'b0;
                loop_done <= 1'b1;
              end
            end else begin
              slot <= slot + NW'(1);
            end
          end
        end
        default: state <= CACHE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtdsp16_cache.sv
module tb_jtdsp16_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cen = 1'b1;
  logic        do_start = 1'b0;
  logic        redo = 1'b0;
  logic [3:0]  do_n = '0;
  logic [6:0]  do_k = '0;
  logic        step = 1'b0;
  logic [15:0] rom_dout = '0;
  logic        cache_en;
  logic [15:0] cache_dout;
  logic        pc_hold;
  logic        busy;
  logic        loop_done;
  logic        nest_err;

  int n_chk = 0;
  int n_fail = 0;

  jtdsp16_cache dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .do_start   (do_start),
    .redo       (redo),
    .do_n       (do_n),
    .do_k       (do_k),
    .step       (step),
    .rom_dout   (rom_dout),
    .cache_en   (cache_en),
    .cache_dout (cache_dout),
    .pc_hold    (pc_hold),
    .busy       (busy),
    .loop_done  (loop_done),
    .nest_err   (nest_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // A loop is a budget of N*K consumed steps. The first N steps of a do
  // come from ROM (and are recorded); everything else is the recorded body
  // indexed by (steps taken mod N).
  bit          m_busy, m_fill, m_done, m_nest;
  int          m_n, m_total, m_cnt;
  logic [15:0] m_mem [15];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_fill = 0; m_done = 0; m_nest = 0;
      m_n = 0; m_total = 0; m_cnt = 0;
      for (int i = 0; i < 15; i++) m_mem[i] = '0;
    end else if (cen) begin
      m_done = 0;
      if (!m_busy) begin
        if (do_start) begin
          if (do_n != 0) begin
            m_n = int'(do_n);
            m_total = m_n * ((do_k == 0) ? 1 : int'(do_k));
            m_cnt = 0; m_fill = 1; m_busy = 1;
          end
        end else if (redo && m_n != 0) begin
          m_total = m_n * ((do_k == 0) ? 1 : int'(do_k));
          m_cnt = 0; m_fill = 0; m_busy = 1;
        end
      end else begin
        if (do_start || redo) m_nest = 1;
        if (step) begin
          if (m_fill && m_cnt < m_n) m_mem[m_cnt] = rom_dout;
          m_cnt++;
          if (m_cnt == m_total) begin
            m_busy = 0; m_done = 1;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    bit          e_en;
    logic [15:0] e_dout;
    #1;
    e_en   = m_busy && !(m_fill && m_cnt < m_n);
    e_dout = e_en ? m_mem[m_cnt % m_n] : 16'h0;
    chk("cache_en",   32'(cache_en),   32'(e_en));
    chk("pc_hold",    32'(pc_hold),    32'(e_en));
    chk("busy",       32'(busy),       32'(m_busy));
    chk("loop_done",  32'(loop_done),  32'(m_done));
    chk("nest_err",   32'(nest_err),   32'(m_nest));
    chk("cache_dout", 32'(cache_dout), 32'(e_dout));
  end

  // consumed-instruction log for literal sequence checks
  logic [15:0] seen [$];
  bit          ever_en;
  always @(posedge clk) begin
    if (cen && step && cache_en) seen.push_back(cache_dout);
    if (cache_en) ever_en = 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input bit is_do, input int n, input int k);
    do_start = is_do; redo = !is_do; do_n = 4'(n); do_k = 7'(k);
    cyc();
    do_start = 0; redo = 0;
  endtask

  task automatic steps(input int cnt, input logic [15:0] base);
    for (int i = 0; i < cnt; i++) begin
      step = 1; rom_dout = base + 16'(i);
      cyc();
    end
    step = 0; rom_dout = 16'hDEAD;
  endtask

  task automatic chk_seq(string nm, input logic [15:0] exp [$]);
    chk({nm, "_len"}, 32'(seen.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < seen.size(); i++)
      chk(nm, 32'(seen[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [15:0] a_seq [$];
    logic [15:0] s15 [$];
    int consumed;
    int c;

    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cache_dout", 32'(cache_dout), 0);
    chk("rst_nest", 32'(nest_err), 0);
    #10 rst = 1;
    cyc();

    // redo right after reset: n_r=0, nothing happens
    start(0, 3, 2);
    chk("redo_after_rst_busy", 32'(busy), 0);

    // basic loop N=3 K=3
    seen.delete();
    start(1, 3, 3);
    chk("do_busy", 32'(busy), 1);
    chk("do_fill_en", 32'(cache_en), 0);
    steps(3, 16'hA000);
    chk("first_replay", 32'(cache_dout), 32'h0000A000);
    chk("first_replay_hold", 32'(pc_hold), 1);
    steps(5, 16'hB000);
    chk("step8_busy", 32'(busy), 1);
    chk("step8_done", 32'(loop_done), 0);
    steps(1, 16'hB100);
    chk("step9_done", 32'(loop_done), 1);
    chk("step9_busy", 32'(busy), 0);
    chk("step9_en", 32'(cache_en), 0);
    a_seq = '{16'hA000, 16'hA001, 16'hA002, 16'hA000, 16'hA001, 16'hA002};
    chk_seq("basic_seq", a_seq);
    cyc();
    chk("done_pulse_end", 32'(loop_done), 0);

    // redo K=2: no FILL, A words twice
    seen.delete();
    start(0, 0, 2);
    chk("redo_en", 32'(cache_en), 1);
    chk("redo_dout", 32'(cache_dout), 32'h0000A000);
    steps(6, 16'hC000);
    chk("redo_done", 32'(loop_done), 1);
    chk_seq("redo_seq", '{16'hA000, 16'hA001, 16'hA002, 16'hA000, 16'hA001, 16'hA002});

    // single pass N=15 K=1, then redo K=1 to read back all 15 slots
    ever_en = 0;
    start(1, 15, 1);
    steps(14, 16'h1000);
    chk("n15_step14_done", 32'(loop_done), 0);
    steps(1, 16'h100E);
    chk("n15_done", 32'(loop_done), 1);
    chk("n15_never_en", 32'(ever_en), 0);
    seen.delete();
    start(0, 0, 1);
    steps(15, 16'hC000);
    chk("n15_redo_done", 32'(loop_done), 1);
    for (int i = 0; i < 15; i++) s15.push_back(16'h1000 + 16'(i));
    chk_seq("n15_slots", s15);

    // enable gating and step stalls
    seen.delete();
    start(1, 3, 3);
    consumed = 0;
    c = 0;
    while (!loop_done && c < 200) begin
      cen = (c % 2 == 0);
      step = (c % 3 != 2);
      rom_dout = 16'hA000 + 16'(consumed);
      cyc();
      if (cen && step) consumed++;
      c++;
    end
    cen = 1; step = 0;
    chk("gate_timeout", 32'(c < 200), 1);
    chk("gate_consumed", 32'(consumed), 9);
    chk_seq("gate_seq", a_seq);

    // nesting: do_start during REPEAT
    seen.delete();
    start(1, 2, 2);
    steps(3, 16'hB000);
    do_start = 1; do_n = 4'd5; do_k = 7'd9;
    steps(1, 16'hEEEE);
    do_start = 0;
    chk("nest_err", 32'(nest_err), 1);
    chk("nest_done", 32'(loop_done), 1);
    chk_seq("nest_seq", '{16'hB000, 16'hB001});
    start(1, 0, 5);
    chk("n0_ignored", 32'(busy), 0);

    // reset mid-FILL
    start(1, 3, 2);
    steps(2, 16'hD000);
    rst = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_nest", 32'(nest_err), 0);
    chk("arst_dout", 32'(cache_dout), 0);
    cyc();
    rst = 1;
    cyc();
    start(0, 0, 2);
    chk("arst_redo_busy", 32'(busy), 0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
